// File: rtl/win_mac_l2_pkg.sv
// Shared layer-2 definitions: FSM states, default datapath widths and counter sizes
// used by the window MAC and the layer-2 address generator.
package win_mac_l2_pkg;
  localparam int unsigned L2_PIX_W  = 8;
  localparam int unsigned L2_WGT_W  = 8;
  localparam int unsigned L2_ACC_W  = 28;
  localparam int unsigned L2_DIM_W  = 9;
  localparam int unsigned L2_CNT_W  = 10;
  localparam int unsigned L2_IDX_W  = 18;
  localparam int unsigned L2_AREA_W = 2 * L2_DIM_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } l2_state_t;
endpackage

// File: rtl/win_mac_l2_if.sv
// Control/data bundle between the layer-2 sequencer side and the window MAC.
interface win_mac_l2_if #(
  parameter int unsigned PIX_W = win_mac_l2_pkg::L2_PIX_W,
  parameter int unsigned WGT_W = win_mac_l2_pkg::L2_WGT_W,
  parameter int unsigned ACC_W = win_mac_l2_pkg::L2_ACC_W
) ();
  import win_mac_l2_pkg::*;

  logic                    start;
  logic                    en;
  logic [L2_DIM_W-1:0]     ht_sm;
  logic [L2_DIM_W-1:0]     wt_sm;
  logic                    conv_done;
  logic [PIX_W-1:0]        pix;
  logic signed [WGT_W-1:0] wgt;
  logic [L2_CNT_W-1:0]     count1;
  logic [L2_CNT_W-1:0]     wgt_addr;
  logic signed [ACC_W-1:0] result;
  logic                    result_valid;
  logic [L2_IDX_W-1:0]     result_idx;
  logic                    busy;
  logic                    done;

  modport master (
    output start, en, ht_sm, wt_sm, conv_done, pix, wgt,
    input  count1, wgt_addr, result, result_valid, result_idx, busy, done
  );

  modport slave (
    input  start, en, ht_sm, wt_sm, conv_done, pix, wgt,
    output count1, wgt_addr, result, result_valid, result_idx, busy, done
  );
endinterface

// File: rtl/win_mac_l2_mac_stage.sv
// Two-stage product/accumulate pipeline: stage 1 registers pix*wgt, stage 2
// accumulates per window and publishes the (optionally ReLU-clamped) sum.
module mac_stage #(
  parameter int unsigned PIX_W = win_mac_l2_pkg::L2_PIX_W,
  parameter int unsigned WGT_W = win_mac_l2_pkg::L2_WGT_W,
  parameter int unsigned ACC_W = win_mac_l2_pkg::L2_ACC_W,
  parameter int unsigned RELU  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    issue,
  input  logic                    issue_first,
  input  logic                    issue_last,
  input  logic [PIX_W-1:0]        pix,
  input  logic signed [WGT_W-1:0] wgt,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid,
  output logic                    pipe_busy
);
  localparam int unsigned PROD_W = PIX_W + WGT_W + 1;

  logic                     s1_v, s1_first, s1_last;
  logic                     s2_v, s2_first, s2_last;
  logic signed [PROD_W-1:0] pix_x, wgt_x, prod_c, prod;
  logic signed [ACC_W-1:0]  acc, acc_next;

  // pix is unsigned: zero-extend it, sign-extend the weight, multiply at full width
  always_comb begin
    pix_x    = PROD_W'({1'b0, pix});
    wgt_x    = PROD_W'(wgt);
    prod_c   = pix_x * wgt_x;
    acc_next = (s2_first ? '0 : acc) + ACC_W'(prod);
  end

  assign pipe_busy = s1_v | s2_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v         <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s2_v         <= 1'b0;
      s2_first     <= 1'b0;
      s2_last      <= 1'b0;
      prod         <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      s1_v         <= issue;
      s1_first     <= issue_first;
      s1_last      <= issue_last;
      s2_v         <= s1_v;
      s2_first     <= s1_first;
      s2_last      <= s1_last;
      result_valid <= s2_v & s2_last;
      if (s1_v) prod <= prod_c;
      if (clr) acc <= '0;
      else if (s2_v) acc <= acc_next;
      if (s2_v && s2_last)
        result <= ((RELU != 0) && acc_next[ACC_W-1]) ? '0 : acc_next;
    end
  end
endmodule

// File: rtl/win_mac_l2.sv
// Layer-2 window MAC: sequences window element indices, feeds the mac_stage
// pipeline and frames a pass with busy/done.
module win_mac_l2
  import win_mac_l2_pkg::*;
#(
  parameter int unsigned PIX_W = L2_PIX_W,
  parameter int unsigned WGT_W = L2_WGT_W,
  parameter int unsigned ACC_W = L2_ACC_W,
  parameter int unsigned RELU  = 1
) (
  input logic         clk,
  input logic         rst,
  win_mac_l2_if.slave bus
);
  localparam logic [L2_AREA_W-1:0] AREA_ONE = L2_AREA_W'(1);

  l2_state_t               state;
  logic [L2_CNT_W-1:0]     count1, limit;
  logic [L2_IDX_W-1:0]     result_idx;
  logic                    busy, done;
  logic [L2_AREA_W-1:0]    area;
  logic                    accept, issue;
  logic                    mac_busy, rv;
  logic signed [ACC_W-1:0] res;

  always_comb begin
    area   = L2_AREA_W'(bus.ht_sm) * L2_AREA_W'(bus.wt_sm);
    accept = (state == IDLE) && bus.start && (area != '0);
    issue  = (state == RUN) && bus.en && !bus.conv_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count1     <= '0;
      limit      <= '0;
      result_idx <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (rv) result_idx <= result_idx + L2_IDX_W'(1);
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state      <= RUN;
            limit      <= L2_CNT_W'(area - AREA_ONE);
            count1     <= '0;
            result_idx <= '0;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (bus.conv_done) state <= DRAIN;
          else if (bus.en) count1 <= (count1 == limit) ? '0 : count1 + L2_CNT_W'(1);
        end
        DRAIN: begin
          // count1 is frozen here; it is only cleared on the way back to IDLE
          if (!mac_busy) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          count1 <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mac_stage #(
    .PIX_W(PIX_W),
    .WGT_W(WGT_W),
    .ACC_W(ACC_W),
    .RELU (RELU)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .clr         (accept),
    .issue       (issue),
    .issue_first (count1 == '0),
    .issue_last  (count1 == limit),
    .pix         (bus.pix),
    .wgt         (bus.wgt),
    .result      (res),
    .result_valid(rv),
    .pipe_busy   (mac_busy)
  );

  assign bus.count1       = count1;
  assign bus.wgt_addr     = count1;
  assign bus.result       = res;
  assign bus.result_valid = rv;
  assign bus.result_idx   = result_idx;
  assign bus.busy         = busy;
  assign bus.done         = done;
endmodule

// File: tb/tb_win_mac_l2.sv
// Bench for win_mac_l2: a ReLU and a raw instance share stimulus and are checked
// every cycle against an event-timed window-sum model, plus literal pins.
module tb_win_mac_l2;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned WGT_W = 8;
  localparam int unsigned ACC_W = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, start, en, conv_done, rand_data;
  logic [8:0]              ht, wt;
  logic [PIX_W-1:0]        pix, cpix;
  logic signed [WGT_W-1:0] wgt, cwgt;

  win_mac_l2_if #(.PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) bus_r ();
  win_mac_l2_if #(.PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) bus_n ();

  win_mac_l2 #(.PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .RELU(1)) dut_r (
    .clk(clk), .rst(rst), .bus(bus_r.slave));
  win_mac_l2 #(.PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .RELU(0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n.slave));

  assign bus_r.start = start;     assign bus_n.start = start;
  assign bus_r.en = en;           assign bus_n.en = en;
  assign bus_r.ht_sm = ht;        assign bus_n.ht_sm = ht;
  assign bus_r.wt_sm = wt;        assign bus_n.wt_sm = wt;
  assign bus_r.conv_done = conv_done; assign bus_n.conv_done = conv_done;
  assign bus_r.pix = pix;         assign bus_n.pix = pix;
  assign bus_r.wgt = wgt;         assign bus_n.wgt = wgt;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  typedef struct { int e; bit f; bit l; } iss_t;
  typedef struct { int due; longint val; } res_t;
  iss_t   iq[$];
  res_t   rq[$];
  int     cyc = 0;
  bit     m_active, m_issuing;
  int     m_done_e, m_last_iss, m_cnt, m_lim;
  longint wsum, p;
  bit     e_rv, e_busy, e_done;
  int     e_idx;
  longint e_res;

  initial forever begin
    iss_t it;
    @(posedge clk);
    cyc++;
    if (rst) begin
      iq.delete(); rq.delete();
      m_active = 0; m_issuing = 0; m_cnt = 0; m_lim = 0; m_done_e = -10;
      e_rv = 0; e_busy = 0; e_done = 0; e_idx = 0; e_res = 0;
    end else begin
      if (e_rv) e_idx++;
      e_rv = 0;
      // operands appear on pix/wgt one cycle after the element is issued
      if (iq.size() > 0 && iq[0].e == cyc - 1) begin
        it = iq.pop_front();
        p = longint'(pix) * longint'(wgt);
        wsum = it.f ? p : wsum + p;
        if (it.l) rq.push_back(res_t'{cyc + 1, wsum});
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e_rv = 1; e_res = rq[0].val; void'(rq.pop_front());
      end
      if (!m_active) begin
        if (start && (int'(ht) * int'(wt)) != 0) begin
          m_active = 1; m_issuing = 1; m_cnt = 0; e_idx = 0; e_busy = 1;
          m_lim = (int'(ht) * int'(wt) - 1) % 1024;
          m_last_iss = -100;
        end
      end else if (m_issuing) begin
        if (conv_done) begin
          m_issuing = 0;
          m_done_e = (cyc + 1 > m_last_iss + 3) ? cyc + 1 : m_last_iss + 3;
        end else if (en) begin
          iq.push_back(iss_t'{cyc, m_cnt == 0, m_cnt == m_lim});
          m_last_iss = cyc;
          m_cnt = (m_cnt == m_lim) ? 0 : m_cnt + 1;
        end
      end else if (cyc == m_done_e) begin
        e_busy = 0; e_done = 1;
      end else if (cyc == m_done_e + 1) begin
        e_done = 0; m_active = 0; m_cnt = 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  bit     lit_en, lit_zero;
  longint lit_res_r, lit_res_n;
  int     lit_gap;
  int     lit_prev = -1;

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("count1_r", bus_r.count1, m_cnt);
      chk("count1_n", bus_n.count1, m_cnt);
      chk("wgt_addr_r", bus_r.wgt_addr, m_cnt);
      chk("wgt_addr_n", bus_n.wgt_addr, m_cnt);
      chk("rv_r", bus_r.result_valid, e_rv);
      chk("rv_n", bus_n.result_valid, e_rv);
      chk("result_r", $signed(bus_r.result), (e_res < 0) ? 0 : e_res);
      chk("result_n", $signed(bus_n.result), e_res);
      chk("idx_r", bus_r.result_idx, e_idx);
      chk("idx_n", bus_n.result_idx, e_idx);
      chk("busy_r", bus_r.busy, e_busy);
      chk("busy_n", bus_n.busy, e_busy);
      chk("done_r", bus_r.done, e_done);
      chk("done_n", bus_n.done, e_done);
      if (bus_r.done) chk("busy_low_at_done", bus_r.busy, 0);
      if (lit_en && bus_r.result_valid) begin
        chk("lit_result_relu", $signed(bus_r.result), lit_res_r);
        chk("lit_result_raw", $signed(bus_n.result), lit_res_n);
        if (lit_prev >= 0 && lit_gap != 0) chk("lit_rv_gap", cyc - lit_prev, lit_gap);
        lit_prev = cyc;
      end
      if (!lit_en) lit_prev = -1;
      if (lit_zero) begin
        chk("zero_count1", bus_r.count1, 0);
        chk("zero_busy", bus_r.busy, 0);
        chk("zero_rv", bus_r.result_valid, 0);
        chk("zero_result", $signed(bus_n.result), 0);
        chk("zero_idx", bus_r.result_idx, 0);
        chk("zero_done", bus_r.done, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial forever begin
    @(negedge clk);
    if (rand_data) begin pix = PIX_W'($urandom); wgt = WGT_W'($urandom); end
    else begin pix = cpix; wgt = cwgt; end
  end

  task automatic run_pass(input int h, input int w, input int cycles, input int en_mode);
    ht = 9'(h); wt = 9'(w); start = 1; en = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < cycles; i++) begin
      en = (en_mode == 1) ? (i % 2 == 0) : 1'b1;
      @(negedge clk);
    end
    conv_done = 1; @(negedge clk); conv_done = 0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1; start = 0; en = 0; conv_done = 0; ht = '0; wt = '0;
    cpix = '0; cwgt = '0; rand_data = 0;
    lit_en = 0; lit_zero = 0; lit_res_r = 0; lit_res_n = 0; lit_gap = 0;
    repeat (3) @(negedge clk);
    rst = 0; lit_zero = 1;
    repeat (2) @(negedge clk);

    // zero-area start is ignored
    ht = 9'd0; wt = 9'd5; start = 1; @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    lit_zero = 0;

    // 2x2, pix=1, wgt=3, en=1
    cpix = 8'd1; cwgt = 8'sd3; @(negedge clk);
    lit_res_r = 12; lit_res_n = 12; lit_gap = 4; lit_en = 1;
    run_pass(2, 2, 12, 0);
    lit_en = 0; @(negedge clk);

    // 1x1, pix=5, wgt=-2
    cpix = 8'd5; cwgt = -8'sd2; @(negedge clk);
    lit_res_r = 0; lit_res_n = -10; lit_gap = 1; lit_en = 1;
    run_pass(1, 1, 10, 0);
    lit_en = 0; @(negedge clk);

    // 2x2 with en toggling
    cpix = 8'd1; cwgt = 8'sd3; @(negedge clk);
    lit_res_r = 12; lit_res_n = 12; lit_gap = 8; lit_en = 1;
    run_pass(2, 2, 24, 1);
    lit_en = 0; @(negedge clk);

    // reset mid-window at count1=2, colliding with start
    rand_data = 1;
    ht = 9'd2; wt = 9'd2; start = 1; en = 1; @(negedge clk);
    start = 0; repeat (2) @(negedge clk);
    rst = 1; start = 1; conv_done = 1; @(negedge clk);
    rst = 0; start = 0; conv_done = 0; lit_zero = 1;
    repeat (6) @(negedge clk);
    lit_zero = 0;

    // randomized passes
    for (int pss = 0; pss < 30; pss++) begin
      int len;
      len = $urandom_range(5, 90);
      ht = 9'($urandom_range(0, 5)); wt = 9'($urandom_range(0, 5));
      if (pss % 7 == 3) begin ht = 9'd9; wt = 9'd9; end
      start = 1; en = 1'($urandom); @(negedge clk);
      start = 0;
      for (int i = 0; i < len; i++) begin
        en = ($urandom % 4) != 0;
        start = ($urandom % 16) == 0;
        rst = ($urandom % 300) == 0;
        ht = 9'($urandom_range(0, 5)); wt = 9'($urandom_range(0, 5));
        @(negedge clk);
      end
      rst = 0; start = 0; conv_done = 1; en = 1; @(negedge clk);
      conv_done = 0; en = 1'($urandom);
      repeat (8) @(negedge clk);
      conv_done = 1'($urandom); @(negedge clk); conv_done = 0;
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/win_mac_l2.md
WIN_MAC_L2 -- requirements
Module: win_mac_l2

Interface
REQ-001 Parameter: PIX_W, 8, unsigned pixel width.
REQ-002 Parameter: WGT_W, 8, signed weight width.
REQ-003 Parameter: ACC_W, 28, signed accumulator/result width.
REQ-004 Parameter: RELU, 1, 1 clamps negative results to 0; 0 passes raw.
REQ-005 Port: clk  input  1  single clock, all logic on rising edge.
REQ-006 Port: rst  input  1  synchronous, active-high reset.
REQ-007 Port: start  input  1  one-cycle pulse beginning a layer-2 pass.
REQ-008 Port: en  input  1  issue enable, shared with the layer-2 address generator.
REQ-009 Port: ht_sm, wt_sm  input  9 each  window height/width, sampled on accepted start.
REQ-010 Port: conv_done  input  1  end-of-pass flag from the layer-2 address generator.
REQ-011 Port: pix  input  PIX_W  image-memory read data, valid one cycle after its address.
REQ-012 Port: wgt  input  WGT_W  kernel-memory read data, valid one cycle after wgt_addr.
REQ-013 Port: count1  output  10  window-element index driving the address generator.
REQ-014 Port: wgt_addr  output  10  kernel address, always equal to count1.
REQ-015 Port: result  output  ACC_W  signed window sum.
REQ-016 Port: result_valid  output  1  one-cycle pulse per completed window.
REQ-017 Port: result_idx  output  18  index of current result, starting at 0 per pass.
REQ-018 Port: busy  output  1  high in RUN and DRAIN.
REQ-019 Port: done  output  1  one-cycle pulse at pass end.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN, DONE; reset enters IDLE.
REQ-021 IDLE->RUN SHALL occur on start=1 when ht_sm*wt_sm != 0; otherwise start SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-022 Accepted start SHALL latch limit = ht_sm*wt_sm-1 (10-bit) and clear count1, result_idx, accumulator.
REQ-023 In RUN with en=1 and conv_done=0, an issue SHALL occur: count1 increments, wrapping to 0 after limit; en=0 SHALL hold count1.
REQ-024 Each issue SHALL tag first=(count1==0), last=(count1==limit) and enter a 2-stage valid pipeline independent of en.
REQ-025 Stage 1 (cycle after issue): product = zero-extended pix x signed wgt, registered, PIX_W+WGT_W+1 bits signed.
REQ-026 Stage 2: acc <= (first ? 0 : acc) + sign-extended product; overflow SHALL wrap two's-complement.
REQ-027 On a last element, result SHALL be the new acc (ReLU-clamped if RELU=1) and result_valid SHALL pulse the following cycle, i.e. 3 cycles after the last issue cycle.
REQ-028 result SHALL hold until the next result_valid; result_idx SHALL increment the cycle after each result_valid.
REQ-029 limit=0 SHALL produce one result per issue, each element being both first and last.
REQ-030 RUN->DRAIN SHALL occur when conv_done=1; no issue SHALL occur in that cycle or after.
REQ-031 DRAIN SHALL last until both pipeline valid bits are 0, then enter DONE.
REQ-032 DONE SHALL assert done for exactly one cycle, then return to IDLE; count1 SHALL read 0 in IDLE.
REQ-033 busy SHALL be 0 in IDLE and DONE.

Reset
REQ-034 rst=1 SHALL clear count1, result, result_valid, result_idx, busy, done, accumulator, pipeline valid bits, and force IDLE, discarding in-flight data.
REQ-035 rst SHALL take priority over start, en and conv_done in the same cycle.

Structure
REQ-036 FSM state encoding and default PIX_W/WGT_W/ACC_W SHALL live in the shared layer-2 package used with the address generator.
REQ-037 The product/accumulate datapath SHALL be one sub-module, mac_stage, holding stages 1-2 and their valid/first/last bits.

Verification
REQ-038 ht_sm=wt_sm=2, pix=1, wgt=3 constant, en=1 -> result=12, result_valid every 4 cycles, first 3 cycles after count1=3.
REQ-039 ht_sm=wt_sm=1, pix=5, wgt=-2 constant, RELU=0 -> result=-10 every cycle after 3-cycle fill; RELU=1 -> result=0.
REQ-040 2x2 window, en toggled 1/0 each cycle -> count1 holds during en=0, result still 12, result_valid spacing 8 cycles.
REQ-041 conv_done=1 asserted right after final issue -> no further count1 change, last result_valid, then done pulse 1 cycle later, busy falls with done.
REQ-042 rst asserted mid-window at count1=2 -> next cycle all outputs 0, IDLE; no result_valid until a new start.
REQ-043 start with ht_sm=0 -> stays IDLE, busy=0, count1=0.
